// File: rtl/dual_rank_pkg.sv
// Shared types and constants for the dual-rank memory controller.
package dual_rank_pkg;

  localparam int WORDADDR_WIDTH_DEF = 7;
  localparam int DATA_WIDTH_DEF     = 8;

  // The rank-select bit sits directly above the word address.
  localparam int RANK_SEL_BIT = WORDADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/dual_rank_mem_ctrl_arb.sv
// Two-input round-robin arbiter; the last-grant history is kept by the parent.
module rr_arbiter2
  import dual_rank_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_grant_i,
  input  logic en_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_valid_o = en_i & (req_a_i | req_b_i);
    if (req_a_i && req_b_i) begin
      grant_id_o = ~last_grant_i;
    end else if (req_b_i) begin
      grant_id_o = REQ_B;
    end else begin
      grant_id_o = REQ_A;
    end
  end

endmodule

// File: rtl/dual_rank_mem_ctrl.sv
// Two-requester controller for a pair of 128x8 synchronous RAM ranks.
//
// state   | meaning
// IDLE    | sample requests, grant one, drive rank pins
// ACCESS  | selected rank performs the operation at the closing edge
// CAPTURE | rank dout valid for reads; ack and rdata loaded at the closing edge
// DONE    | ack high for one cycle; no sampling
module dual_rank_mem_ctrl
  import dual_rank_pkg::*;
#(
  parameter int WORDADDR_WIDTH = WORDADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req,
  input  logic                      a_wr,
  input  logic [WORDADDR_WIDTH:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]     a_wdata,
  output logic                      a_ack,
  output logic [DATA_WIDTH-1:0]     a_rdata,
  input  logic                      b_req,
  input  logic                      b_wr,
  input  logic [WORDADDR_WIDTH:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]     b_wdata,
  output logic                      b_ack,
  output logic [DATA_WIDTH-1:0]     b_rdata,
  output logic                      r0_cs,
  output logic                      r1_cs,
  output logic                      rk_wr,
  output logic [WORDADDR_WIDTH-1:0] rk_addr,
  output logic [DATA_WIDTH-1:0]     rk_din,
  input  logic [DATA_WIDTH-1:0]     r0_dout,
  input  logic [DATA_WIDTH-1:0]     r1_dout,
  output logic                      busy
);

  state_e                    state_q;
  logic                      last_grant_q;
  logic                      win_q;
  logic                      wr_q;
  logic                      rank_q;
  logic                      r0_cs_q;
  logic                      r1_cs_q;
  logic                      rk_wr_q;
  logic [WORDADDR_WIDTH-1:0] rk_addr_q;
  logic [DATA_WIDTH-1:0]     rk_din_q;
  logic                      a_ack_q;
  logic                      b_ack_q;
  logic [DATA_WIDTH-1:0]     a_rdata_q;
  logic [DATA_WIDTH-1:0]     b_rdata_q;
  logic                      busy_q;

  logic                      grant_valid;
  logic                      grant_id;
  logic                      sel_wr;
  logic [WORDADDR_WIDTH:0]   sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic [DATA_WIDTH-1:0]     rank_dout;

  rr_arbiter2 u_arb (
    .req_a_i       (a_req),
    .req_b_i       (b_req),
    .last_grant_i  (last_grant_q),
    .en_i          (state_q == ST_IDLE),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign sel_wr    = (grant_id == REQ_B) ? b_wr    : a_wr;
  assign sel_addr  = (grant_id == REQ_B) ? b_addr  : a_addr;
  assign sel_wdata = (grant_id == REQ_B) ? b_wdata : a_wdata;
  assign rank_dout = rank_q ? r1_dout : r0_dout;

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_B;
      win_q        <= REQ_A;
      wr_q         <= 1'b0;
      rank_q       <= 1'b0;
      r0_cs_q      <= 1'b0;
      r1_cs_q      <= 1'b0;
      rk_wr_q      <= 1'b0;
      rk_addr_q    <= '0;
      rk_din_q     <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            win_q        <= grant_id;
            wr_q         <= sel_wr;
            rank_q       <= sel_addr[WORDADDR_WIDTH];
            r0_cs_q      <= ~sel_addr[WORDADDR_WIDTH];
            r1_cs_q      <= sel_addr[WORDADDR_WIDTH];
            rk_wr_q      <= sel_wr;
            rk_addr_q    <= sel_addr[WORDADDR_WIDTH-1:0];
            rk_din_q     <= sel_wdata;
            last_grant_q <= grant_id;
            busy_q       <= 1'b1;
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r0_cs_q <= 1'b0;
          r1_cs_q <= 1'b0;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (win_q == REQ_B) begin
            b_ack_q <= 1'b1;
            if (!wr_q) b_rdata_q <= rank_dout;
          end else begin
            a_ack_q <= 1'b1;
            if (!wr_q) a_rdata_q <= rank_dout;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign r0_cs   = r0_cs_q;
  assign r1_cs   = r1_cs_q;
  assign rk_wr   = rk_wr_q;
  assign rk_addr = rk_addr_q;
  assign rk_din  = rk_din_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = busy_q;

endmodule
